// File: rtl/posit_quire_norm.sv
// Three-stage, multi-lane normaliser: signed quire words -> sign, scale factor and
// rounded 1.f mantissa for the posit encoder. All lanes share one valid/ready pipeline.
module posit_quire_norm #(
  parameter int WIDTH   = 8,
  parameter int EXP     = 2,
  parameter int K       = 9,
  parameter int LANES   = 1,
  parameter int WK      = $clog2(K),
  parameter int BIAS    = 2**(EXP+1)*(WIDTH-2),
  parameter int WIDTH_A = WK+2*BIAS+2,
  parameter int MW      = 2*(WIDTH-2-EXP),
  parameter int SFW     = $clog2(WIDTH)+EXP+2
) (
  input  logic                     clk_i,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     rnd_mode,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [LANES*WIDTH_A-1:0] acc,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [LANES-1:0]         sign_q,
  output logic [LANES-1:0]         zero_q,
  output logic [LANES-1:0]         inexact_q,
  output logic [LANES*SFW-1:0]     sf_q,
  output logic [LANES*MW-1:0]      mts_q
);
  localparam int PW = $clog2(WIDTH_A);

  logic adv;
  logic v1, v2, v3;
  logic r1, r2;

  // Every stage advances together; a stalled output freezes the whole pipe.
  assign adv     = ~v3 | out_rdy;
  assign in_rdy  = adv;
  assign out_vld = v3;

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      r1 <= 1'b0;
      r2 <= 1'b0;
    end else begin
      if (flush) begin
        v1 <= 1'b0;
        v2 <= 1'b0;
        v3 <= 1'b0;
      end else if (adv) begin
        v1 <= in_vld;
        v2 <= v1;
        v3 <= v2;
      end
      if (adv) begin
        r1 <= rnd_mode;
        r2 <= r1;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH_A-1:0] a_w;
    logic               s1_sign, s1_zero;
    logic [WIDTH_A-1:0] s1_mag;
    logic               s2_sign, s2_zero;
    logic [WIDTH_A-1:0] s2_norm;
    logic [SFW-1:0]     s2_sf;
    logic               s3_sign, s3_zero, s3_inex;
    logic [SFW-1:0]     s3_sf;
    logic [MW-1:0]      s3_mts;
    logic [PW-1:0]      lead, shamt;
    logic [SFW-1:0]     sf_d;
    logic [MW-1:0]      mant;
    logic               guard, sticky, inc;
    logic [MW:0]        sum;

    assign a_w = acc[i*WIDTH_A +: WIDTH_A];

    always_comb begin
      lead = '0;
      for (int b = 0; b < WIDTH_A; b++)
        if (s1_mag[b]) lead = PW'(b);
    end

    assign shamt = PW'(WIDTH_A-1) - lead;
    assign sf_d  = SFW'(int'(lead) - BIAS);

    // Bits shifted in below the original bit 0 are zero, which is the zero padding.
    assign mant   = s2_norm[WIDTH_A-1 -: MW];
    assign guard  = s2_norm[WIDTH_A-1-MW];
    assign sticky = |s2_norm[WIDTH_A-2-MW:0];
    assign inc    = r2 & guard & (sticky | mant[0]);
    assign sum    = {1'b0, mant} + {{MW{1'b0}}, inc};

    always_ff @(posedge clk_i or negedge rstn) begin
      if (!rstn) begin
        s1_sign <= 1'b0;
        s1_zero <= 1'b0;
        s1_mag  <= '0;
        s2_sign <= 1'b0;
        s2_zero <= 1'b0;
        s2_norm <= '0;
        s2_sf   <= '0;
        s3_sign <= 1'b0;
        s3_zero <= 1'b0;
        s3_inex <= 1'b0;
        s3_sf   <= '0;
        s3_mts  <= '0;
      end else if (adv) begin
        s1_sign <= a_w[WIDTH_A-1];
        s1_zero <= (a_w == '0);
        s1_mag  <= a_w[WIDTH_A-1] ? -a_w : a_w;

        s2_sign <= s1_sign;
        s2_zero <= s1_zero;
        s2_norm <= s1_mag << shamt;
        s2_sf   <= sf_d;

        if (s2_zero) begin
          s3_sign <= 1'b0;
          s3_zero <= 1'b1;
          s3_inex <= 1'b0;
          s3_sf   <= '0;
          s3_mts  <= '0;
        end else begin
          s3_sign <= s2_sign;
          s3_zero <= 1'b0;
          s3_inex <= guard | sticky;
          if (sum[MW]) begin
            s3_mts <= {1'b1, {(MW-1){1'b0}}};
            s3_sf  <= s2_sf + SFW'(1);
          end else begin
            s3_mts <= sum[MW-1:0];
            s3_sf  <= s2_sf;
          end
        end
      end
    end

    assign sign_q[i]               = s3_sign;
    assign zero_q[i]               = s3_zero;
    assign inexact_q[i]            = s3_inex;
    assign sf_q[i*SFW +: SFW]      = s3_sf;
    assign mts_q[i*MW +: MW]       = s3_mts;
  end
endmodule
